// File: rtl/serial_complementer_if.sv
// Handshake and data bundle for serial_complementer.
// Upstream word channel (in_*), downstream result channel (out_*) and a busy flag.
// The master modport is the side that supplies words and consumes results;
// the slave modport is the complementer itself.
interface serial_complementer_if #(
   parameter int W = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_ovf;
   logic          busy;

   modport master (
      output in_valid,
      output in_data,
      output in_mode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_ovf,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_mode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_ovf,
      output busy
   );
endinterface

// File: rtl/serial_complementer.sv
// serial_complementer: bit-serial pass / ones-complement / twos-complement /
// absolute-value unit. A word is accepted in IDLE, processed one bit per cycle
// LSB first in SHIFT, and held in DONE until the downstream side takes it.
// Optional feature macro: SERIAL_COMP_SAT_EN -- when defined, an overflowing
// twos/abs result (operand is the most negative value) is replaced by the
// most positive value; otherwise the wrapped value (the operand) is returned.
// out_ovf flags the overflow in both builds.
module serial_complementer #(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_complementer_if.slave  bus
);

   localparam int          CW       = $clog2(W);
   localparam logic [CW-1:0] LAST   = CW'(W - 1);
   localparam logic [W-1:0]  MOSTNEG = {1'b1, {(W-1){1'b0}}};
`ifdef SERIAL_COMP_SAT_EN
   localparam logic [W-1:0]  MOSTPOS = {1'b0, {(W-1){1'b1}}};
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    op_q, op_d;
   logic [1:0]      mode_q, mode_d;
   logic            msb_q, msb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            seen_one_q, seen_one_d;
   logic [W-1:0]    res_q, res_d;
   logic            ovf_q, ovf_d;

   logic            bit_in;
   logic            invert;
   logic            bit_out;
   logic            is_ovf;

   // Per-bit transform: decide whether the current operand bit is inverted.
   // Twos-complement copies up to and including the first 1 and inverts after;
   // absolute value applies that rule only to negative operands.
   always_comb begin
      bit_in  = op_q[cnt_q];
      invert  = 1'b0;
      case (mode_q)
         2'b00:   invert = 1'b0;
         2'b01:   invert = 1'b1;
         2'b10:   invert = seen_one_q;
         2'b11:   invert = msb_q & seen_one_q;
         default: invert = 1'b0;
      endcase
      bit_out = bit_in ^ invert;
      is_ovf  = mode_q[1] && (op_q == MOSTNEG);
   end

   // Next-state and datapath update for the IDLE / SHIFT / DONE sequence.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mode_d     = mode_q;
      msb_d      = msb_q;
      cnt_d      = cnt_q;
      seen_one_d = seen_one_q;
      res_d      = res_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d       = bus.in_data;
               mode_d     = bus.in_mode;
               msb_d      = bus.in_data[W-1];
               cnt_d      = '0;
               seen_one_d = 1'b0;
               ovf_d      = 1'b0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            res_d      = {bit_out, res_q[W-1:1]};
            seen_one_d = seen_one_q | bit_in;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               ovf_d   = is_ovf;
               state_d = DONE;
`ifdef SERIAL_COMP_SAT_EN
               if (is_ovf) begin
                  res_d = MOSTPOS;
               end
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any word in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         mode_q     <= 2'b00;
         msb_q      <= 1'b0;
         cnt_q      <= '0;
         seen_one_q <= 1'b0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         mode_q     <= mode_d;
         msb_q      <= msb_d;
         cnt_q      <= cnt_d;
         seen_one_q <= seen_one_d;
         res_q      <= res_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_data  = res_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_complementer.sv
// Scoreboard bench for serial_complementer (W=8). Stimulus pushes the
// hand-computed result into a queue; a monitor pops and compares on every
// output transfer. Handles both builds of SERIAL_COMP_SAT_EN.
module tb_serial_complementer;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct packed {
      logic [W-1:0] data;
      logic         ovf;
   } exp_t;

   exp_t expQ[$];

   serial_complementer_if #(.W(W)) bus ();

   serial_complementer #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: on each output transfer pop the next expected result and compare.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_output", 32'(bus.out_data), 32'hDEAD);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
            checkOutput("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
         end
      end
   end

   // Offer a word, push its expected result, scramble inputs after acceptance,
   // then return the number of cycles until out_valid rises (0 if it never does).
   task automatic applyStimulus(input logic [W-1:0] d, input logic [1:0] m,
                                input logic [W-1:0] ed, input logic eo,
                                output int lat);
      int waited;
      waited = 0;
      while (!bus.in_ready && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      expQ.push_back('{data: ed, ovf: eo});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
      bus.in_mode  = ~m;
      checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   // Run one word with out_ready high and check latency.
   task automatic runWord(input logic [W-1:0] d, input logic [1:0] m,
                          input logic [W-1:0] ed, input logic eo);
      int lat;
      applyStimulus(d, m, ed, eo, lat);
      checkOutput("latency", 32'(lat), 32'd8);
      @(posedge clk); #1;
      checkOutput("in_ready_after_transfer", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      checks = 0;
      errors = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_mode  = 2'b00;
      bus.out_ready = 1'b1;
      #1;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors.
      runWord(8'h05, 2'b10, 8'hFB, 1'b0);
      runWord(8'h00, 2'b10, 8'h00, 1'b0);
`ifdef SERIAL_COMP_SAT_EN
      runWord(8'h80, 2'b11, 8'h7F, 1'b1);
      runWord(8'h80, 2'b10, 8'h7F, 1'b1);
`else
      runWord(8'h80, 2'b11, 8'h80, 1'b1);
      runWord(8'h80, 2'b10, 8'h80, 1'b1);
`endif
      runWord(8'hF0, 2'b11, 8'h10, 1'b0);
      runWord(8'h35, 2'b11, 8'h35, 1'b0);
      runWord(8'hFF, 2'b11, 8'h01, 1'b0);
      runWord(8'h00, 2'b01, 8'hFF, 1'b0);
      runWord(8'h80, 2'b01, 8'h7F, 1'b0);
      runWord(8'hA5, 2'b00, 8'hA5, 1'b0);
      runWord(8'h01, 2'b10, 8'hFF, 1'b0);

      // Backpressure: result held for 5 cycles, a second word is ignored.
      bus.out_ready = 1'b0;
      applyStimulus(8'h05, 2'b10, 8'hFB, 1'b0, lat);
      checkOutput("bp_latency", 32'(lat), 32'd8);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      bus.in_mode  = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("bp_out_data", 32'(bus.out_data), 32'hFB);
         checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
      checkOutput("bp_out_valid_after", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of SHIFT discards the word.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h05;
      bus.in_mode  = 2'b10;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("mid_rst_out_data", 32'(bus.out_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      checkOutput("no_valid_after_reset", 32'(seen), 32'd0);
      runWord(8'h01, 2'b10, 8'hFF, 1'b0);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_complementer.md
SERIAL_COMPLEMENTER -- requirements
Module: serial_complementer

Interface
REQ-001 Parameter W, default 8: data word width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream word present on in_data/in_mode.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  W  operand, bit 0 = LSB.
REQ-007 in_mode  input  2  operation: 00 pass, 01 ones-complement, 10 twos-complement, 11 absolute value (signed).
REQ-008 out_valid  output  1  result present on out_data/out_ovf.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_data  output  W  result word.
REQ-011 out_ovf  output  1  result not representable; see REQ-020.
REQ-012 busy  output  1  high in SHIFT or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, latch in_data, in_mode and the operand MSB; clear bit counter and seen-one flag; go to SHIFT.
REQ-015 SHIFT: process one bit per cycle, LSB first, for exactly W cycles (counter 0..W-1); after bit W-1 go to DONE. in_ready=0.
REQ-016 Per-bit rule: pass -> copy; ones -> invert; twos -> copy bits up to and including the first 1, invert all later bits; abs -> twos rule if latched MSB=1, else copy.
REQ-017 DONE: out_valid=1; out_data and out_ovf held stable until out_valid&&out_ready; on that edge go to IDLE.
REQ-018 Latency: out_valid SHALL rise exactly W cycles after the accepting edge; the next word can be accepted no earlier than the cycle after the output transfer (one word per W+2 cycles minimum).
REQ-019 in_valid in SHIFT/DONE SHALL be ignored; in_data/in_mode changes after acceptance SHALL NOT affect the result.
REQ-020 out_ovf=1 iff mode is twos or abs and the operand equals the most negative value (1 followed by W-1 zeros); otherwise 0. Twos of zero SHALL yield zero with out_ovf=0.
REQ-021 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, out_ovf=0, counter=0, seen-one flag=0.
REQ-023 Reset during SHIFT or DONE SHALL discard the word in progress; no out_valid pulse SHALL follow reset release.
REQ-024 First acceptance is possible on the first rising edge with rst_n high.

Configuration
REQ-025 Macro SERIAL_COMP_SAT_EN: when defined, an overflow result (REQ-020) SHALL be replaced by the most positive value (0 followed by W-1 ones), with out_ovf=1.
REQ-026 Without SERIAL_COMP_SAT_EN, an overflow result SHALL be the wrapped value (equal to the operand) with out_ovf=1; no saturation logic synthesised.

Verification (W=8)
REQ-027 mode 10, data 0x05, out_ready=1 -> out_data 0xFB, out_ovf 0, out_valid exactly 8 cycles after accept; mode 10, data 0x00 -> 0x00, ovf 0.
REQ-028 mode 11, data 0x80 -> with macro 0x7F/ovf 1, without 0x80/ovf 1; mode 11, data 0xF0 -> 0x10; mode 11, data 0x35 -> 0x35.
REQ-029 mode 01, data 0x00 -> 0xFF; mode 00, data 0xA5 -> 0xA5; both ovf 0.
REQ-030 Backpressure: result 0xFB held with out_ready=0 for 5 cycles -> out_data stable, in_ready 0, a second in_valid with 0x11 ignored; after transfer in_ready 1 next cycle.
REQ-031 rst_n low 3 cycles after accepting 0x05 -> out_valid never asserts for it; after release, 0x01 mode 10 -> 0xFF after 8 cycles.
